// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: initiator side of the data-RAM port (IDLE -> ACCESS -> RESP).
// Optional macro LSU_MISALIGN_SPLIT_EN splits misaligned loads into two word reads.
module rv32i_lsu #(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic [1:0]        rsp_err_o,
  output logic              stall_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_mode_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: a request is taken on the rising edge where req_valid_i & req_ready_o;
  // a response is held stable from rsp_valid_o until the edge where rsp_ready_i is also 1.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
    , S_ACCESS2 = 2'd3
`endif
  } state_e;

  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);

  state_e              state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic                split_q, split_d;
  logic [31:0]         lo_q, lo_d;
  logic [31:0]         ld_split;
`endif

  logic [ADDR_W:0]     req_base;
  logic                bad_f3, misal, oor, split_ok, split_acc;
  logic [4:0]          lane_sh;
  logic [31:0]         ld_word, st_data;
  logic [3:0]          st_mode;
  logic [ADDR_W-1:0]   base_q;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'b0, w[7:0]};
      3'b101:  extend = {16'b0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  // Fault classification of the incoming request, evaluated before it is latched.
  always_comb begin
    req_base = {1'b0, req_addr_i[ADDR_W-1:2], 2'b00};
    bad_f3   = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    misal    = bad_f3
            || ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
            || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    split_ok = misal && !bad_f3 && !req_store_i;
`else
    split_ok = 1'b0;
`endif
    oor = ((req_base + (ADDR_W+1)'(3)) >= MEM_LIM)
       || (split_ok && ((req_base + (ADDR_W+1)'(7)) >= MEM_LIM));
  end

  // Lane placement for stores and lane extraction for loads from the latched request.
  always_comb begin
    lane_sh = {addr_q[1:0], 3'b000};
    base_q  = {addr_q[ADDR_W-1:2], 2'b00};
    ld_word = ram_data_i >> lane_sh;
`ifdef LSU_MISALIGN_SPLIT_EN
    ld_split  = 32'({ram_data_i, lo_q} >> lane_sh);
    split_acc = split_q;
`else
    split_acc = 1'b0;
`endif
    case (funct3_q[1:0])
      2'b00: begin
        st_mode = 4'b0001 << addr_q[1:0];
        st_data = {24'b0, wdata_q[7:0]} << lane_sh;
      end
      2'b01: begin
        st_mode = 4'b0011 << addr_q[1:0];
        st_data = {16'b0, wdata_q[15:0]} << lane_sh;
      end
      default: begin
        st_mode = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d  = split_q;
    lo_d     = lo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          store_d  = req_store_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          rdata_d  = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d  = split_ok;
`endif
          // Faulted requests skip the RAM cycle entirely.
          if (oor) begin
            err_d   = 2'b10;
            state_d = S_RESP;
          end else if (misal && !split_ok) begin
            err_d   = 2'b01;
            state_d = S_RESP;
          end else begin
            err_d   = 2'b00;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (!store_q) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            lo_d    = ram_data_i;
            state_d = S_ACCESS2;
          end else begin
            rdata_d = extend(funct3_q, ld_word);
          end
`else
          rdata_d = extend(funct3_q, ld_word);
`endif
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ACCESS2: begin
        rdata_d = extend(funct3_q, ld_split);
        state_d = S_RESP;
      end
`endif
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    stall_o     = (state_q != S_IDLE);
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = '0;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_mode_o  = '0;
    ram_addr_o  = '0;
    ram_data_o  = '0;
    dbg_state_o = state_q;
    case (state_q)
      S_ACCESS: begin
        ram_ce_o   = !store_q;
        ram_we_o   = store_q;
        ram_mode_o = split_acc ? 4'b1111 : st_mode;
        ram_addr_o = base_q;
        ram_data_o = st_data;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_ACCESS2: begin
        ram_ce_o   = 1'b1;
        ram_mode_o = 4'b1111;
        ram_addr_o = base_q + ADDR_W'(4);
      end
`endif
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q  <= 1'b0;
      lo_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q  <= split_d;
      lo_q     <= lo_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: byte-array reference model, word RAM behind the DUT,
// directed boundary cases plus randomized load/store traffic.
`timescale 1ns/1ps
module tb_rv32i_lsu;
  localparam int ADDR_W    = 32;
  localparam int MEM_BYTES = 800;
  localparam int RAM_WORDS = MEM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o, req_store_i = 1'b0;
  logic [2:0]  req_funct3_i = '0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_err_o;
  logic        stall_o, ram_ce_o, ram_we_o;
  logic [3:0]  ram_mode_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [31:0] ram [0:RAM_WORDS-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  logic        mon_en = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          edges, ce_n, we_n, both_n, stall_bad;
    logic [31:0] addr0, addr1, st_data;
    logic [3:0]  st_mode;
    logic        ready_after, valid_after;
  } obs_t;

  rv32i_lsu #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .stall_o(stall_o), .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o),
    .ram_mode_o(ram_mode_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .dbg_state_o(dbg_state)
  );

  // Clock / reset block, RAM environment and response monitor
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign ram_data_i = ((ram_addr_o >> 2) < RAM_WORDS) ? ram[ram_addr_o >> 2] : 32'h0;

  always @(posedge clk) begin
    if (ram_we_o && ((ram_addr_o >> 2) < RAM_WORDS))
      for (int i = 0; i < 4; i++)
        if (ram_mode_o[i]) ram[ram_addr_o >> 2][8*i +: 8] <= ram_data_o[8*i +: 8];
  end

  always @(negedge clk) begin
    if (mon_en && rsp_valid_o && rsp_ready_i) got_q.push_back({rsp_err_o, rsp_rdata_o});
  end

  task automatic init_mem();
    logic [31:0] v;
    for (int w = 0; w < RAM_WORDS; w++) begin
      v = $urandom;
      if (w == 0) v = 32'h12345678;
      if (w == 1) v = 32'h87654321;
      if (w == 2) v = 32'h0010FFE7;
      if (w == 3) v = 32'hFF02FE80;
      ram[w] = v;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
    end
  endtask

  // Reference model: byte-addressed little-endian memory, access-size rules applied directly.
  task automatic ref_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] er,
                            output int edges, output int ce_n, output int we_n,
                            output logic [3:0] mode, output logic [31:0] data);
    int size, off;
    longint al;
    logic bad, mis, split;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    off   = int'(a % 4);
    al    = longint'(a) - off;
    mis   = bad || ((a % size) != 0);
`ifdef LSU_MISALIGN_SPLIT_EN
    split = mis && !bad && !st;
`else
    split = 1'b0;
`endif
    rd = '0; mode = '0; data = '0; edges = 0; ce_n = 0; we_n = 0;
    if ((al + 3 >= MEM_BYTES) || (split && (al + 7 >= MEM_BYTES))) er = 2'd2;
    else if (mis && !split) er = 2'd1;
    else begin
      er = 2'd0;
      edges = split ? 2 : 1;
      if (st) begin
        we_n = 1;
        for (int i = 0; i < size; i++) begin
          ref_mem[int'(a) + i] = wd[8*i +: 8];
          mode[off + i] = 1'b1;
          data[8*(off + i) +: 8] = wd[8*i +: 8];
        end
      end else begin
        ce_n = split ? 2 : 1;
        for (int i = 0; i < size; i++) rd[8*i +: 8] = ref_mem[int'(a) + i];
        if (f3 == 3'b000 && rd[7])  rd[31:8]  = '1;
        if (f3 == 3'b001 && rd[15]) rd[31:16] = '1;
      end
    end
  endtask

  // Driver: issue one request, observe the RAM side until the response, then retire it.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output obs_t o);
    o.rdata = '0; o.err = '0; o.edges = 0; o.ce_n = 0; o.we_n = 0; o.both_n = 0;
    o.stall_bad = 0; o.addr0 = '0; o.addr1 = '0; o.st_data = '0; o.st_mode = '0;
    @(negedge clk);
    req_valid_i = 1'b1; req_store_i = st; req_funct3_i = f3; req_addr_i = a; req_wdata_i = wd;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    while (!rsp_valid_o && o.edges < 10) begin
      if (ram_ce_o || ram_we_o) begin
        if (o.ce_n + o.we_n == 0) o.addr0 = ram_addr_o; else o.addr1 = ram_addr_o;
      end
      if (ram_ce_o) o.ce_n++;
      if (ram_we_o) begin o.we_n++; o.st_mode = ram_mode_o; o.st_data = ram_data_o; end
      if (ram_ce_o && ram_we_o) o.both_n++;
      if (!stall_o) o.stall_bad++;
      @(posedge clk); #1;
      o.edges++;
    end
    o.rdata = rsp_rdata_o;
    o.err   = rsp_err_o;
    @(posedge clk); #1;
    o.ready_after = req_ready_o;
    o.valid_after = rsp_valid_o;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, stall_o, ram_ce_o, ram_we_o, ram_mode_o,
         ram_addr_o, ram_data_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero (valid=%b ce=%b we=%b stall=%b) exp all 0",
                         rsp_valid_o, ram_ce_o, ram_we_o, stall_o);
    end
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready_o); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1 || stall_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: ready=%b stall=%b exp 1/0", req_ready_o, stall_o);
    end
  endtask

  task automatic test_directed_loads();
    logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] adrs [4] = '{32'd12, 32'd12, 32'd8, 32'd10};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFE7, 32'h00000010};
    obs_t o;
    for (int k = 0; k < 4; k++) begin
      do_req(1'b0, f3s[k], adrs[k], 32'h0, o);
      checks++;
      if (o.rdata !== exps[k] || o.err !== 2'b00) begin
        errors++; $display("FAIL dir_load%0d: got %h/err%0d exp %h/err0", k, o.rdata, o.err, exps[k]);
      end
      checks++;
      if (o.edges !== 1 || o.ce_n !== 1 || o.we_n !== 0 || o.addr0 !== (adrs[k] & ~32'h3)) begin
        errors++; $display("FAIL dir_load%0d_ram: edges=%0d ce=%0d we=%0d addr=%h exp 1/1/0/%h",
                           k, o.edges, o.ce_n, o.we_n, o.addr0, adrs[k] & ~32'h3);
      end
    end
    do_req(1'b0, 3'b010, 32'd2, 32'h0, o);
`ifdef LSU_MISALIGN_SPLIT_EN
    checks++;
    if (o.rdata !== 32'h43211234 || o.err !== 2'b00 || o.edges !== 2) begin
      errors++; $display("FAIL lw2_split: got %h/err%0d/edges%0d exp 43211234/err0/edges2",
                         o.rdata, o.err, o.edges);
    end
    checks++;
    if (o.ce_n !== 2 || o.addr0 !== 32'd0 || o.addr1 !== 32'd4 || o.we_n !== 0) begin
      errors++; $display("FAIL lw2_split_ram: ce=%0d a0=%h a1=%h we=%0d exp 2/0/4/0",
                         o.ce_n, o.addr0, o.addr1, o.we_n);
    end
`else
    checks++;
    if (o.err !== 2'b01 || o.rdata !== 32'h0 || o.ce_n !== 0 || o.we_n !== 0) begin
      errors++; $display("FAIL lw2_misalign: err=%0d rdata=%h ce=%0d we=%0d exp 1/0/0/0",
                         o.err, o.rdata, o.ce_n, o.we_n);
    end
`endif
  endtask

  task automatic test_faults();
    obs_t o;
    logic [31:0] e_rd, e_dat;
    logic [1:0]  e_er;
    logic [3:0]  e_mode;
    int e_ed, e_ce, e_we;
    do_req(1'b0, 3'b010, 32'd800, 32'h0, o);
    checks++;
    if (o.err !== 2'b10 || o.rdata !== 32'h0 || o.ce_n + o.we_n !== 0 || o.edges !== 0) begin
      errors++; $display("FAIL lw800_range: err=%0d rdata=%h ram=%0d edges=%0d exp 2/0/0/0",
                         o.err, o.rdata, o.ce_n + o.we_n, o.edges);
    end
    do_req(1'b1, 3'b001, 32'd3, $urandom, o);
    checks++;
    if (o.err !== 2'b01 || o.we_n !== 0 || o.ce_n !== 0) begin
      errors++; $display("FAIL sh3_misalign: err=%0d we=%0d ce=%0d exp 1/0/0", o.err, o.we_n, o.ce_n);
    end
    ref_access(1'b0, 3'b010, 32'd796, 32'h0, e_rd, e_er, e_ed, e_ce, e_we, e_mode, e_dat);
    do_req(1'b0, 3'b010, 32'd796, 32'h0, o);
    checks++;
    if (o.rdata !== e_rd || o.err !== e_er) begin
      errors++; $display("FAIL lw796_last: got %h/err%0d exp %h/err%0d", o.rdata, o.err, e_rd, e_er);
    end
  endtask

  task automatic test_store_lanes();
    obs_t o;
    logic [31:0] e_rd, e_dat;
    logic [1:0]  e_er;
    logic [3:0]  e_mode;
    int e_ed, e_ce, e_we;
    ref_access(1'b1, 3'b000, 32'd5, 32'h000000AA, e_rd, e_er, e_ed, e_ce, e_we, e_mode, e_dat);
    do_req(1'b1, 3'b000, 32'd5, 32'h000000AA, o);
    checks++;
    if (o.addr0 !== 32'd4 || o.st_mode !== 4'b0010 || o.st_data !== 32'h0000AA00 ||
        o.we_n !== 1 || o.ce_n !== 0 || o.err !== 2'b00) begin
      errors++; $display("FAIL sb5_lanes: addr=%h mode=%b data=%h we=%0d ce=%0d exp 4/0010/0000aa00/1/0",
                         o.addr0, o.st_mode, o.st_data, o.we_n, o.ce_n);
    end
    do_req(1'b0, 3'b010, 32'd4, 32'h0, o);
    checks++;
    if (o.rdata !== 32'h8765AA21) begin
      errors++; $display("FAIL lw4_after_sb: got %h exp 8765aa21", o.rdata);
    end
    ref_access(1'b1, 3'b001, 32'd6, 32'h1234BEEF, e_rd, e_er, e_ed, e_ce, e_we, e_mode, e_dat);
    do_req(1'b1, 3'b001, 32'd6, 32'h1234BEEF, o);
    checks++;
    if (o.st_mode !== 4'b1100 || o.st_data !== 32'hBEEF0000) begin
      errors++; $display("FAIL sh6_lanes: mode=%b data=%h exp 1100/beef0000", o.st_mode, o.st_data);
    end
    do_req(1'b0, 3'b010, 32'd4, 32'h0, o);
    checks++;
    if (o.rdata !== 32'hBEEFAA21) begin
      errors++; $display("FAIL lw4_after_sh: got %h exp beefaa21", o.rdata);
    end
  endtask

  task automatic test_hold_rsp();
    int n;
    @(negedge clk);
    req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'd12;
    rsp_ready_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 10) begin @(posedge clk); #1; n++; end
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFF02FE80) begin
      errors++; $display("FAIL hold_first: valid=%b rdata=%h exp 1/ff02fe80", rsp_valid_o, rsp_rdata_o);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFF02FE80 || stall_o !== 1'b1 ||
          req_ready_o !== 1'b0 || ram_ce_o !== 1'b0 || ram_we_o !== 1'b0) begin
        errors++; $display("FAIL hold_cycle%0d: valid=%b rdata=%h stall=%b ready=%b exp 1/ff02fe80/1/0",
                           k, rsp_valid_o, rsp_rdata_o, stall_o, req_ready_o);
      end
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || stall_o !== 1'b0) begin
      errors++; $display("FAIL hold_release: valid=%b ready=%b stall=%b exp 0/1/0",
                         rsp_valid_o, req_ready_o, stall_o);
    end
  endtask

  task automatic test_reset_in_access();
    obs_t o;
    @(negedge clk);
    req_valid_i = 1'b1; req_store_i = 1'b1; req_funct3_i = 3'b010; req_addr_i = 32'd0;
    req_wdata_i = 32'hDEADBEEF; rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    checks++;
    if (ram_we_o !== 1'b1) begin errors++; $display("FAIL sw0_access_we: got %b exp 1", ram_we_o); end
    rst = 1'b0;
    #1;
    checks++;
    if (ram_ce_o !== 1'b0 || ram_we_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL async_reset_drop: ce=%b we=%b valid=%b ready=%b exp 0/0/0/1",
                         ram_ce_o, ram_we_o, rsp_valid_o, req_ready_o);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready_o !== 1'b1 || stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b stall=%b exp 1/0", req_ready_o, stall_o);
    end
    do_req(1'b0, 3'b010, 32'd0, 32'h0, o);
    checks++;
    if (o.rdata !== 32'h12345678) begin
      errors++; $display("FAIL word0_kept: got %h exp 12345678", o.rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, wd, e_rd, e_dat;
    logic [1:0]  e_er;
    logic [3:0]  e_mode;
    int pick, e_ed, e_ce, e_we;
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  bad_f3 [3] = '{3'd3, 3'd6, 3'd7};
    for (int it = 0; it < 60; it++) begin
      st   = ($urandom_range(0, 2) == 0);
      pick = $urandom_range(0, 9);
      wd   = $urandom;
      a    = $urandom_range(0, MEM_BYTES - 9);
      if (pick == 0) f3 = bad_f3[$urandom_range(0, 2)];
      else if (pick == 1) begin
        f3 = st ? 3'd0 : ($urandom_range(0, 1) ? 3'd0 : 3'd4);
        a  = $urandom_range(MEM_BYTES - 4, MEM_BYTES + 3);
      end else f3 = st ? ld_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      ref_access(st, f3, a, wd, e_rd, e_er, e_ed, e_ce, e_we, e_mode, e_dat);
      do_req(st, f3, a, wd, o);
      checks++;
      if (o.err !== e_er || o.rdata !== e_rd) begin
        errors++; $display("FAIL rnd%0d_rsp: st=%b f3=%0d a=%0d got %h/err%0d exp %h/err%0d",
                           it, st, f3, a, o.rdata, o.err, e_rd, e_er);
      end
      checks++;
      if (o.edges !== e_ed || o.ce_n !== e_ce || o.we_n !== e_we || o.both_n !== 0 ||
          o.stall_bad !== 0 || o.ready_after !== 1'b1 || o.valid_after !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_timing: edges=%0d ce=%0d we=%0d both=%0d exp %0d/%0d/%0d/0",
                           it, o.edges, o.ce_n, o.we_n, o.both_n, e_ed, e_ce, e_we);
      end
      if (e_ce + e_we > 0) begin
        checks++;
        if (o.addr0 !== (a & ~32'h3)) begin
          errors++; $display("FAIL rnd%0d_addr: got %h exp %h", it, o.addr0, a & ~32'h3);
        end
      end
      if (e_we > 0) begin
        checks++;
        if (o.st_mode !== e_mode || o.st_data !== e_dat) begin
          errors++; $display("FAIL rnd%0d_lanes: mode=%b data=%h exp %b/%h",
                             it, o.st_mode, o.st_data, e_mode, e_dat);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int w;
    logic [2:0]  f3;
    logic [31:0] a, e_rd, e_dat;
    logic [1:0]  e_er;
    logic [3:0]  e_mode;
    int e_ed, e_ce, e_we;
    logic [33:0] exp_v, got_v;
    logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    exp_q.delete(); got_q.delete();
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      f3 = ld_f3[$urandom_range(0, 4)];
      a  = 32'($urandom_range(0, RAM_WORDS - 2) * 4) + ((f3[1:0] == 2'b00) ? 32'($urandom_range(0, 3)) :
           (f3[1:0] == 2'b01) ? 32'(2 * $urandom_range(0, 1)) : 32'd0);
      ref_access(1'b0, f3, a, 32'h0, e_rd, e_er, e_ed, e_ce, e_we, e_mode, e_dat);
      exp_q.push_back({e_er, e_rd});
      @(negedge clk);
      req_valid_i = 1'b1; req_store_i = 1'b0; req_funct3_i = f3; req_addr_i = a; rsp_ready_i = 1'b1;
      w = 0;
      while (!req_ready_o && w < 10) begin @(negedge clk); w++; end
      acc[k] = cyc_cnt;
      if (k > 0) begin
        checks++;
        if (acc[k] - acc[k-1] !== 3) begin
          errors++; $display("FAIL b2b_spacing%0d: got %0d cycles exp 3", k, acc[k] - acc[k-1]);
        end
      end
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d responses exp %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = got_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL b2b_data: got %h exp %h", got_v, exp_v);
      end
    end
  endtask

  initial begin
    init_mem();
    test_reset();
    test_directed_loads();
    test_faults();
    test_store_lanes();
    test_hold_rsp();
    test_reset_in_access();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
